// File: rtl/k_means_pkg.sv
// rtl/k_means_pkg.sv - shared types, frame constants and width helpers for the k-means engine
package k_means_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ACCUM,
        ST_DRAIN,
        ST_DIVIDE,
        ST_DONE
    } state_t;

    localparam int FRAME_WIDTH  = 320;
    localparam int FRAME_HEIGHT = 180;
    localparam int DRAIN_CYCLES = 2;

    // Manhattan distance needs one bit more than the wider axis.
    function automatic int dist_width(input int xw, input int yw);
        return ((xw > yw) ? xw : yw) + 1;
    endfunction

endpackage

// File: rtl/argmin_k.sv
// rtl/argmin_k.sv - registered argmin over MAX_K distances, masked to the active count
module argmin_k #(
    parameter int MAX_K = 8,
    parameter int DW    = 10,
    parameter int KW    = $clog2(MAX_K + 1),
    parameter int IW    = (MAX_K > 1) ? $clog2(MAX_K) : 1
) (
    input  logic                     clk_in,
    input  logic                     rst_in,
    input  logic                     flush_in,
    input  logic                     valid_in,
    input  logic [MAX_K-1:0][DW-1:0] dist_in,
    input  logic [KW-1:0]            active_in,
    output logic                     valid_out,
    output logic [IW-1:0]            idx_out
);
    logic [DW-1:0] best_dist;
    logic [IW-1:0] idx_d, idx_q;
    logic          valid_d, valid_q;

    // Cluster 0 is always active; strict < keeps ties on the lowest index.
    always_comb begin
        best_dist = dist_in[0];
        idx_d     = '0;
        for (int j = 1; j < MAX_K; j++) begin
            if ((KW'(j) < active_in) && (dist_in[j] < best_dist)) begin
                best_dist = dist_in[j];
                idx_d     = IW'(j);
            end
        end
        valid_d = valid_in && !flush_in;
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            idx_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            idx_q   <= idx_d;
            valid_q <= valid_d;
        end
    end

    assign valid_out = valid_q;
    assign idx_out   = idx_q;

endmodule

// File: rtl/divider.sv
// rtl/divider.sv - sequential restoring unsigned divider, one quotient bit per cycle
module divider #(
    parameter int WIDTH = 32
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             data_valid_in,
    input  logic [WIDTH-1:0] dividend_in,
    input  logic [WIDTH-1:0] divisor_in,
    output logic [WIDTH-1:0] quotient_out,
    output logic [WIDTH-1:0] remainder_out,
    output logic             data_valid_out
);
    localparam int CW = $clog2(WIDTH + 1);

    logic [WIDTH-1:0] quo_q, quo_d, rem_q, rem_d, div_q, div_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             busy_q, busy_d, valid_q, valid_d;
    logic [WIDTH:0]   trial;
    logic [WIDTH-1:0] diff;

    always_comb begin
        quo_d   = quo_q;
        rem_d   = rem_q;
        div_d   = div_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        valid_d = 1'b0;
        trial   = {rem_q, quo_q[WIDTH-1]};
        // Only the low bits matter: the subtraction is used only when trial >= divisor.
        diff    = trial[WIDTH-1:0] - div_q;
        if (busy_q) begin
            if (trial >= {1'b0, div_q}) begin
                rem_d = diff;
                quo_d = {quo_q[WIDTH-2:0], 1'b1};
            end else begin
                rem_d = trial[WIDTH-1:0];
                quo_d = {quo_q[WIDTH-2:0], 1'b0};
            end
            cnt_d = cnt_q - CW'(1);
            if (cnt_q == CW'(1)) begin
                busy_d  = 1'b0;
                valid_d = 1'b1;
            end
        end
        // A new request restarts the unit even if an older one is still in flight.
        if (data_valid_in) begin
            quo_d   = dividend_in;
            rem_d   = '0;
            div_d   = divisor_in;
            cnt_d   = CW'(WIDTH);
            busy_d  = 1'b1;
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            quo_q   <= '0;
            rem_q   <= '0;
            div_q   <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            quo_q   <= quo_d;
            rem_q   <= rem_d;
            div_q   <= div_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            valid_q <= valid_d;
        end
    end

    assign quotient_out   = quo_q;
    assign remainder_out  = rem_q;
    assign data_valid_out = valid_q;

endmodule

// File: rtl/k_means_stream.sv
// rtl/k_means_stream.sv - streaming k-means: nearest-centroid accumulation and one Lloyd update per frame
module k_means_stream
    import k_means_pkg::*;
#(
    parameter int MAX_K       = 8,
    parameter int X_WIDTH     = $clog2(FRAME_WIDTH),
    parameter int Y_WIDTH     = $clog2(FRAME_HEIGHT),
    parameter int SUM_WIDTH   = 25,
    parameter int CONV_THRESH = 1
) (
    input  logic                          clk_in,
    input  logic                          rst_in,
    input  logic                          seed_valid_in,
    input  logic [MAX_K-1:0][X_WIDTH-1:0] centroids_x_in,
    input  logic [MAX_K-1:0][Y_WIDTH-1:0] centroids_y_in,
    input  logic [$clog2(MAX_K+1)-1:0]    num_clusters_in,
    input  logic [X_WIDTH-1:0]            x_in,
    input  logic [Y_WIDTH-1:0]            y_in,
    input  logic                          pixel_valid_in,
    output logic                          pixel_ready_out,
    input  logic                          frame_end_in,
    output logic [MAX_K-1:0][X_WIDTH-1:0] centroids_x_out,
    output logic [MAX_K-1:0][Y_WIDTH-1:0] centroids_y_out,
    output logic                          data_valid_out,
    input  logic                          data_ready_in,
    output logic                          converged_out,
    output logic                          overflow_out
);
    localparam int KW = $clog2(MAX_K + 1);
    localparam int IW = (MAX_K > 1) ? $clog2(MAX_K) : 1;
    localparam int DW = dist_width(X_WIDTH, Y_WIDTH);

    state_t                            state_q, state_d;
    logic [KW-1:0]                     k_q, k_d;
    logic [MAX_K-1:0][X_WIDTH-1:0]     cx_q, cx_d;
    logic [MAX_K-1:0][Y_WIDTH-1:0]     cy_q, cy_d;
    logic [MAX_K-1:0][SUM_WIDTH-1:0]   xs_q, xs_d, ys_q, ys_d, ms_q, ms_d;
    logic                              ovf_q, ovf_d, conv_q, conv_d, conv_acc_q, conv_acc_d;
    logic [1:0]                        drain_q, drain_d;
    logic [IW-1:0]                     div_idx_q, div_idx_d;
    logic                              div_busy_q, div_busy_d, div_axis_q, div_axis_d;
    logic [X_WIDTH-1:0]                qx_q, qx_d;

    logic                              s1_valid_q, s1_valid_d;
    logic [X_WIDTH-1:0]                s1_x_q, s1_x_d, s2_x_q;
    logic [Y_WIDTH-1:0]                s1_y_q, s1_y_d, s2_y_q;
    logic [MAX_K-1:0][DW-1:0]          s1_dist_q, s1_dist_d;

    logic                              pix_fire, am_valid;
    logic [IW-1:0]                     am_idx;
    logic                              div_start, div_valid, advance;
    logic [SUM_WIDTH-1:0]              div_dividend, div_divisor, div_quo, div_rem;
    logic                              sat_x, sat_y, sat_m;
    logic [X_WIDTH-1:0]                new_x;
    logic [Y_WIDTH-1:0]                new_y;
    logic                              unused_div_bits;

    function automatic logic [SUM_WIDTH:0] sat_add(input logic [SUM_WIDTH-1:0] a,
                                                   input logic [SUM_WIDTH-1:0] b);
        logic [SUM_WIDTH:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s[SUM_WIDTH]) return {1'b1, {SUM_WIDTH{1'b1}}};
        return s;
    endfunction

    function automatic logic moved(input int a, input int b);
        return ((a > b) ? (a - b) : (b - a)) > CONV_THRESH;
    endfunction

    // A seed on the same cycle wins, so the pixel is not handshaken away.
    assign pixel_ready_out = (state_q == ST_ACCUM) && !seed_valid_in;
    assign pix_fire        = pixel_valid_in && pixel_ready_out;

    always_comb begin
        s1_valid_d = pix_fire && !seed_valid_in;
        s1_x_d     = x_in;
        s1_y_d     = y_in;
        for (int j = 0; j < MAX_K; j++) begin
            s1_dist_d[j] = DW'((x_in >= cx_q[j]) ? (x_in - cx_q[j]) : (cx_q[j] - x_in))
                         + DW'((y_in >= cy_q[j]) ? (y_in - cy_q[j]) : (cy_q[j] - y_in));
        end
    end

    argmin_k #(
        .MAX_K (MAX_K),
        .DW    (DW),
        .KW    (KW),
        .IW    (IW)
    ) u_argmin (
        .clk_in    (clk_in),
        .rst_in    (rst_in),
        .flush_in  (seed_valid_in),
        .valid_in  (s1_valid_q),
        .dist_in   (s1_dist_q),
        .active_in (k_q),
        .valid_out (am_valid),
        .idx_out   (am_idx)
    );

    assign div_dividend = div_axis_q ? ys_q[div_idx_q] : xs_q[div_idx_q];
    assign div_divisor  = ms_q[div_idx_q];

    divider #(
        .WIDTH (SUM_WIDTH)
    ) u_divider (
        .clk_in         (clk_in),
        .rst_in         (rst_in),
        .data_valid_in  (div_start),
        .dividend_in    (div_dividend),
        .divisor_in     (div_divisor),
        .quotient_out   (div_quo),
        .remainder_out  (div_rem),
        .data_valid_out (div_valid)
    );

    assign unused_div_bits = ^{div_quo[SUM_WIDTH-1:X_WIDTH], div_rem};

    always_comb begin
        state_d    = state_q;
        k_d        = k_q;
        cx_d       = cx_q;
        cy_d       = cy_q;
        xs_d       = xs_q;
        ys_d       = ys_q;
        ms_d       = ms_q;
        conv_d     = conv_q;
        conv_acc_d = conv_acc_q;
        drain_d    = drain_q;
        div_idx_d  = div_idx_q;
        div_busy_d = div_busy_q;
        div_axis_d = div_axis_q;
        qx_d       = qx_q;
        div_start  = 1'b0;
        advance    = 1'b0;
        sat_x      = 1'b0;
        sat_y      = 1'b0;
        sat_m      = 1'b0;
        new_x      = qx_q;
        new_y      = div_quo[Y_WIDTH-1:0];

        if (am_valid) begin
            for (int j = 0; j < MAX_K; j++) begin
                if (IW'(j) == am_idx) begin
                    {sat_x, xs_d[j]} = sat_add(xs_q[j], SUM_WIDTH'(s2_x_q));
                    {sat_y, ys_d[j]} = sat_add(ys_q[j], SUM_WIDTH'(s2_y_q));
                    {sat_m, ms_d[j]} = sat_add(ms_q[j], SUM_WIDTH'(1));
                end
            end
        end
        ovf_d = ovf_q | sat_x | sat_y | sat_m;

        case (state_q)
            ST_ACCUM: begin
                if (frame_end_in) begin
                    state_d = ST_DRAIN;
                    drain_d = '0;
                end
            end
            ST_DRAIN: begin
                if (drain_q == 2'(DRAIN_CYCLES - 1)) begin
                    state_d    = ST_DIVIDE;
                    div_idx_d  = '0;
                    div_busy_d = 1'b0;
                    div_axis_d = 1'b0;
                    conv_acc_d = 1'b1;
                end else begin
                    drain_d = drain_q + 2'd1;
                end
            end
            ST_DIVIDE: begin
                // Per cluster: x quotient, then y quotient; empty clusters keep their centroid.
                if (!div_busy_q) begin
                    if (div_divisor == '0) begin
                        advance = 1'b1;
                    end else begin
                        div_start  = 1'b1;
                        div_busy_d = 1'b1;
                    end
                end else if (div_valid) begin
                    div_busy_d = 1'b0;
                    if (!div_axis_q) begin
                        qx_d       = div_quo[X_WIDTH-1:0];
                        div_axis_d = 1'b1;
                    end else begin
                        div_axis_d = 1'b0;
                        if (moved(int'(new_x), int'(cx_q[div_idx_q])) ||
                            moved(int'(new_y), int'(cy_q[div_idx_q]))) begin
                            conv_acc_d = 1'b0;
                        end
                        cx_d[div_idx_q] = new_x;
                        cy_d[div_idx_q] = new_y;
                        advance         = 1'b1;
                    end
                end
            end
            ST_DONE: begin
                if (data_ready_in) begin
                    state_d = ST_ACCUM;
                    xs_d    = '0;
                    ys_d    = '0;
                    ms_d    = '0;
                end
            end
            default: ;
        endcase

        if (advance) begin
            if (KW'(div_idx_q) == k_q - KW'(1)) begin
                state_d = ST_DONE;
                conv_d  = conv_acc_d;
            end else begin
                div_idx_d = div_idx_q + IW'(1);
            end
        end

        if (seed_valid_in) begin
            state_d    = ST_ACCUM;
            cx_d       = centroids_x_in;
            cy_d       = centroids_y_in;
            xs_d       = '0;
            ys_d       = '0;
            ms_d       = '0;
            ovf_d      = 1'b0;
            conv_d     = 1'b0;
            div_busy_d = 1'b0;
            div_axis_d = 1'b0;
            if (num_clusters_in == '0) begin
                k_d = KW'(1);
            end else if (num_clusters_in > KW'(MAX_K)) begin
                k_d = KW'(MAX_K);
            end else begin
                k_d = num_clusters_in;
            end
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q    <= ST_IDLE;
            k_q        <= KW'(1);
            cx_q       <= '0;
            cy_q       <= '0;
            xs_q       <= '0;
            ys_q       <= '0;
            ms_q       <= '0;
            ovf_q      <= 1'b0;
            conv_q     <= 1'b0;
            conv_acc_q <= 1'b0;
            drain_q    <= '0;
            div_idx_q  <= '0;
            div_busy_q <= 1'b0;
            div_axis_q <= 1'b0;
            qx_q       <= '0;
            s1_valid_q <= 1'b0;
            s1_x_q     <= '0;
            s1_y_q     <= '0;
            s1_dist_q  <= '0;
            s2_x_q     <= '0;
            s2_y_q     <= '0;
        end else begin
            state_q    <= state_d;
            k_q        <= k_d;
            cx_q       <= cx_d;
            cy_q       <= cy_d;
            xs_q       <= xs_d;
            ys_q       <= ys_d;
            ms_q       <= ms_d;
            ovf_q      <= ovf_d;
            conv_q     <= conv_d;
            conv_acc_q <= conv_acc_d;
            drain_q    <= drain_d;
            div_idx_q  <= div_idx_d;
            div_busy_q <= div_busy_d;
            div_axis_q <= div_axis_d;
            qx_q       <= qx_d;
            s1_valid_q <= s1_valid_d;
            s1_x_q     <= s1_x_d;
            s1_y_q     <= s1_y_d;
            s1_dist_q  <= s1_dist_d;
            s2_x_q     <= s1_x_q;
            s2_y_q     <= s1_y_q;
        end
    end

    assign centroids_x_out = cx_q;
    assign centroids_y_out = cy_q;
    assign data_valid_out  = (state_q == ST_DONE);
    assign converged_out   = conv_q;
    assign overflow_out    = ovf_q;

endmodule
